// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous frame FIFO.
// Pointer widths carry one wrap bit above the address bits.
package fifo_pkg;

   typedef logic [31:0] word_t;

   function automatic int unsigned cnt_w(input int unsigned log2);
      return log2 + 1;
   endfunction

   function automatic int unsigned depth_of(input int unsigned log2);
      return 32'd1 << log2;
   endfunction

   // wrap-bit subtraction, result kept to pw bits (0..2**(pw-1))
   function automatic word_t ptr_diff(
      input word_t       a,
      input word_t       b,
      input int unsigned pw
   );
      word_t mask;
      mask = (word_t'(1) << pw) - word_t'(1);
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read output holds its value while re is low.
module sdp_ram
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = 9,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int unsigned DEPTH = depth_of(ADDR_W);

   logic [WIDTH-1:0] mem [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_frame_fifo.sv
// Frame FIFO: beats become readable only after their frame commits.
// Uncommitted frames can be aborted; read side is FWFT valid/ready.
module sync_frame_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DEPTH_LOG2   = 11,
   parameter int unsigned DROP_ON_FULL = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   input  logic                  wr_drop,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   input  logic                  rd_ready,
   input  logic [DEPTH_LOG2:0]   afull_th,
   input  logic [DEPTH_LOG2:0]   aempty_th,
   output logic [DEPTH_LOG2:0]   level,
   output logic [DEPTH_LOG2:0]   frame_cnt,
   output logic                  full,
   output logic                  afull,
   output logic                  aempty,
   output logic                  drop_pulse
);

   localparam int unsigned PW = cnt_w(DEPTH_LOG2);
   localparam int unsigned AW = DEPTH_LOG2;
   localparam int unsigned MW = DATA_WIDTH + 1;
   localparam bit          DOF = (DROP_ON_FULL != 0);

   typedef logic [PW-1:0] ptr_t;

   localparam ptr_t P_ONE   = PW'(1);
   localparam ptr_t P_DEPTH = PW'(depth_of(DEPTH_LOG2));

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t commit_ptr_q, commit_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t acc_ptr_q, acc_ptr_d;
   ptr_t level_q, level_d;
   ptr_t frame_cnt_q, frame_cnt_d;

   logic full_q, afull_q, aempty_q;
   logic poison_q, poison_d;
   logic drop_pulse_q, drop_pulse_d;

   logic          mem_we, mem_re;
   logic [MW-1:0] mem_q;
   logic          ram_vld_q;
   logic          out_vld_q, skid_vld_q;
   logic [MW-1:0] out_q, skid_q;

   logic hit_full, poisoned, uncommitted;
   logic commit, pop, push, retire_last;

   assign wr_ready    = DOF || !full_q;
   assign hit_full    = DOF && wr_valid && full_q;
   assign poisoned    = poison_q || hit_full;
   assign uncommitted = (wr_ptr_q != commit_ptr_q);

   // fetch ahead only when the ram stage will be free; rd_ready unused here
   assign mem_re = (rd_ptr_q != commit_ptr_q)
                && (!ram_vld_q || !skid_vld_q);
   assign push        = ram_vld_q && !skid_vld_q;
   assign pop         = out_vld_q && rd_ready;
   assign retire_last = pop && out_q[MW-1];

   sdp_ram #(
      .WIDTH  (MW),
      .ADDR_W (AW)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata ({wr_last, wr_data}),
      .re    (mem_re),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (mem_q)
   );

   // write side: accept, commit, abort and overflow poisoning
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      poison_d     = poison_q;
      drop_pulse_d = 1'b0;
      mem_we       = 1'b0;
      commit       = 1'b0;
      if (wr_drop) begin
         wr_ptr_d     = commit_ptr_q;
         poison_d     = 1'b0;
         drop_pulse_d = uncommitted || poison_q;
      end else if (wr_valid && poisoned) begin
         if (wr_last) begin
            wr_ptr_d     = commit_ptr_q;
            poison_d     = 1'b0;
            drop_pulse_d = 1'b1;
         end else begin
            poison_d = 1'b1;
         end
      end else if (wr_valid && wr_ready) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + P_ONE;
         if (wr_last) begin
            commit_ptr_d = wr_ptr_q + P_ONE;
            commit       = 1'b1;
         end
      end
   end

   // read pointers, frame count and occupancy
   always_comb begin
      rd_ptr_d  = mem_re ? rd_ptr_q + P_ONE : rd_ptr_q;
      acc_ptr_d = pop ? acc_ptr_q + P_ONE : acc_ptr_q;
      level_d   = PW'(ptr_diff(word_t'(wr_ptr_d),
                               word_t'(acc_ptr_d), PW));
      unique case ({commit, retire_last})
         2'b10:   frame_cnt_d = frame_cnt_q + P_ONE;
         2'b01:   frame_cnt_d = frame_cnt_q - P_ONE;
         default: frame_cnt_d = frame_cnt_q;
      endcase
   end

   // pointer, count and status flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         acc_ptr_q    <= '0;
         level_q      <= '0;
         frame_cnt_q  <= '0;
         full_q       <= 1'b0;
         afull_q      <= 1'b0;
         aempty_q     <= 1'b1;
         poison_q     <= 1'b0;
         drop_pulse_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         acc_ptr_q    <= acc_ptr_d;
         level_q      <= level_d;
         frame_cnt_q  <= frame_cnt_d;
         full_q       <= (level_d == P_DEPTH);
         afull_q      <= (level_d >= afull_th);
         aempty_q     <= (level_d <= aempty_th);
         poison_q     <= poison_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   // two-entry output skid fed from the registered ram read
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_vld_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         ram_vld_q <= mem_re || (ram_vld_q && !push);
         if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
               out_q      <= skid_q;
               out_vld_q  <= 1'b1;
               skid_vld_q <= 1'b0;
            end else if (push) begin
               out_q     <= mem_q;
               out_vld_q <= 1'b1;
            end else begin
               out_vld_q <= 1'b0;
            end
         end else if (push) begin
            skid_q     <= mem_q;
            skid_vld_q <= 1'b1;
         end
      end
   end

   assign rd_valid   = out_vld_q;
   assign rd_data    = out_q[DATA_WIDTH-1:0];
   assign rd_last    = out_q[MW-1];
   assign level      = level_q;
   assign frame_cnt  = frame_cnt_q;
   assign full       = full_q;
   assign afull      = afull_q;
   assign aempty     = aempty_q;
   assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_sync_frame_fifo.sv
// Self-checking bench for sync_frame_fifo (DATA_WIDTH=8, DEPTH_LOG2=4).
// Two instances: backpressure mode and drop-on-full mode.
module tb_sync_frame_fifo;

   localparam int PW = 5;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      int n;
      int ath;
      int eth;
      int lvl;
      int full;
      int afull;
      int aempty;
      int fc;
      int wrdy;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_last = 1'b0;
   logic          wr_drop = 1'b0;
   logic          rd_ready = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic [PW-1:0] afull_th = 5'd12;
   logic [PW-1:0] aempty_th = 5'd2;
   bit            sel = 1'b0;

   logic          wv0, wv1, wdr0, wdr1, rr0, rr1;
   logic          wrdy0, wrdy1, rv0, rv1, rl0, rl1;
   logic [7:0]    rd0, rd1;
   logic [PW-1:0] lv0, lv1, fc0, fc1;
   logic          fu0, fu1, af0, af1, ae0, ae1, dp0, dp1;

   logic          wr_ready, rd_valid, rd_last;
   logic [7:0]    rd_data;
   logic [PW-1:0] level, frame_cnt;
   logic          full, afull, aempty, drop_pulse;

   int    tests = 0;
   int    fails = 0;
   int    pulses = 0;
   beat_t sb[$];
   beat_t pend[$];
   beat_t exp_b;

   assign wv0  = wr_valid && !sel;
   assign wv1  = wr_valid && sel;
   assign wdr0 = wr_drop && !sel;
   assign wdr1 = wr_drop && sel;
   assign rr0  = rd_ready && !sel;
   assign rr1  = rd_ready && sel;

   assign wr_ready   = sel ? wrdy1 : wrdy0;
   assign rd_valid   = sel ? rv1 : rv0;
   assign rd_data    = sel ? rd1 : rd0;
   assign rd_last    = sel ? rl1 : rl0;
   assign level      = sel ? lv1 : lv0;
   assign frame_cnt  = sel ? fc1 : fc0;
   assign full       = sel ? fu1 : fu0;
   assign afull      = sel ? af1 : af0;
   assign aempty     = sel ? ae1 : ae0;
   assign drop_pulse = sel ? dp1 : dp0;

   sync_frame_fifo #(
      .DATA_WIDTH(8), .DEPTH_LOG2(4), .DROP_ON_FULL(0)
   ) dut0 (
      .clk(clk), .rst(rst),
      .wr_valid(wv0), .wr_data(wr_data), .wr_last(wr_last),
      .wr_drop(wdr0), .wr_ready(wrdy0),
      .rd_valid(rv0), .rd_data(rd0), .rd_last(rl0), .rd_ready(rr0),
      .afull_th(afull_th), .aempty_th(aempty_th),
      .level(lv0), .frame_cnt(fc0),
      .full(fu0), .afull(af0), .aempty(ae0), .drop_pulse(dp0)
   );

   sync_frame_fifo #(
      .DATA_WIDTH(8), .DEPTH_LOG2(4), .DROP_ON_FULL(1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .wr_valid(wv1), .wr_data(wr_data), .wr_last(wr_last),
      .wr_drop(wdr1), .wr_ready(wrdy1),
      .rd_valid(rv1), .rd_data(rd1), .rd_last(rl1), .rd_ready(rr1),
      .afull_th(afull_th), .aempty_th(aempty_th),
      .level(lv1), .frame_cnt(fc1),
      .full(fu1), .afull(af1), .aempty(ae1), .drop_pulse(dp1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: got timeout expected completion", nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard pop at negedge, well clear of the active edge
   always @(negedge clk) begin
      if (!rst && drop_pulse) pulses++;
      if (!rst && rd_valid && rd_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got %0d expected none",
                     rd_data);
         end else begin
            exp_b = sb.pop_front();
            chk("rd_data", 32'(rd_data), 32'(exp_b.d));
            chk("rd_last", 32'(rd_last), 32'(exp_b.l));
         end
      end
   end

   task automatic put(input logic [7:0] d, input logic l,
                      input bit keep);
      int n;
      n = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = l;
      while (!wr_ready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) fail_now("wr_ready_wait");
      step();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      if (keep) begin
         pend.push_back('{d: d, l: l});
         if (l) begin
            foreach (pend[i]) sb.push_back(pend[i]);
            pend.delete();
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      rd_ready = 1'b1;
      while ((sb.size() != 0 || rd_valid) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) fail_now("drain");
      rd_ready = 1'b0;
      step();
      chk("drain_level", 32'(level), 0);
      chk("drain_frame_cnt", 32'(frame_cnt), 0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      wr_drop  = 1'b0;
      rd_ready = 1'b0;
      step();
      rst = 1'b0;
      sb.delete();
      pend.delete();
   endtask

   task automatic chk_reset(input string t);
      chk({t, "_wr_ready"},   32'(wr_ready), 1);
      chk({t, "_rd_valid"},   32'(rd_valid), 0);
      chk({t, "_rd_data"},    32'(rd_data), 0);
      chk({t, "_rd_last"},    32'(rd_last), 0);
      chk({t, "_level"},      32'(level), 0);
      chk({t, "_frame_cnt"},  32'(frame_cnt), 0);
      chk({t, "_full"},       32'(full), 0);
      chk({t, "_afull"},      32'(afull), 0);
      chk({t, "_aempty"},     32'(aempty), 1);
      chk({t, "_drop_pulse"}, 32'(drop_pulse), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[8];
      int   n;
      int   p0;
      // n beats, afull_th, aempty_th -> level full afull aempty fc wr_ready
      tv[0] = '{0,  12, 2, 0,  0, 0, 1, 0, 1};
      tv[1] = '{2,  12, 2, 2,  0, 0, 1, 1, 1};
      tv[2] = '{3,  12, 2, 3,  0, 0, 0, 1, 1};
      tv[3] = '{11, 12, 2, 11, 0, 0, 0, 1, 1};
      tv[4] = '{12, 12, 2, 12, 0, 1, 0, 1, 1};
      tv[5] = '{16, 12, 2, 16, 1, 1, 0, 1, 0};
      tv[6] = '{5,  5,  5, 5,  0, 1, 1, 1, 1};
      tv[7] = '{1,  0,  0, 1,  0, 1, 0, 1, 1};

      sel = 1'b0;
      do_reset();
      chk_reset("rst");

      foreach (tv[i]) begin
         afull_th  = PW'(tv[i].ath);
         aempty_th = PW'(tv[i].eth);
         do_reset();
         for (int k = 0; k < tv[i].n; k++)
            put(8'(i * 16 + k), k == tv[i].n - 1, 1'b1);
         step();
         chk($sformatf("tv%0d_level", i), 32'(level), tv[i].lvl);
         chk($sformatf("tv%0d_full", i), 32'(full), tv[i].full);
         chk($sformatf("tv%0d_afull", i), 32'(afull), tv[i].afull);
         chk($sformatf("tv%0d_aempty", i), 32'(aempty), tv[i].aempty);
         chk($sformatf("tv%0d_fc", i), 32'(frame_cnt), tv[i].fc);
         chk($sformatf("tv%0d_wr_ready", i), 32'(wr_ready), tv[i].wrdy);
         drain();
      end
      afull_th  = 5'd12;
      aempty_th = 5'd2;

      // commit latency and back-to-back read
      do_reset();
      rd_ready = 1'b1;
      for (int k = 0; k < 4; k++) put(8'(16 + k), k == 3, 1'b1);
      chk("lat_n0_valid", 32'(rd_valid), 0);
      chk("lat_n0_fc", 32'(frame_cnt), 1);
      step();
      chk("lat_n1_valid", 32'(rd_valid), 0);
      step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b_valid%0d", k), 32'(rd_valid), 1);
         step();
      end
      chk("b2b_end_valid", 32'(rd_valid), 0);
      chk("b2b_end_fc", 32'(frame_cnt), 0);
      rd_ready = 1'b0;

      // abort an uncommitted frame
      for (int k = 0; k < 3; k++) put(8'(k + 1), 1'b0, 1'b0);
      chk("drop_level_pre", 32'(level), 3);
      wr_drop = 1'b1;
      step();
      wr_drop = 1'b0;
      chk("drop_level_post", 32'(level), 0);
      chk("drop_pulse", 32'(drop_pulse), 1);
      step();
      chk("drop_pulse_once", 32'(drop_pulse), 0);
      wr_drop = 1'b1;
      step();
      wr_drop = 1'b0;
      chk("drop_noop_pulse", 32'(drop_pulse), 0);
      put(8'h55, 1'b0, 1'b0);
      wr_valid = 1'b1;
      wr_data  = 8'h56;
      wr_last  = 1'b1;
      wr_drop  = 1'b1;
      step();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      wr_drop  = 1'b0;
      chk("drop_wins_level", 32'(level), 0);
      chk("drop_wins_fc", 32'(frame_cnt), 0);
      chk("drop_wins_pulse", 32'(drop_pulse), 1);
      put(8'hA0, 1'b0, 1'b1);
      put(8'hA1, 1'b1, 1'b1);
      drain();

      // backpressure at full
      do_reset();
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < 4; k++)
            put(8'(32 + f * 4 + k), k == 3, 1'b1);
      chk("bp_wr_ready", 32'(wr_ready), 0);
      chk("bp_full", 32'(full), 1);
      chk("bp_level", 32'(level), 16);
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      wr_last  = 1'b1;
      step();
      step();
      chk("bp_stall_level", 32'(level), 16);
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      rd_ready = 1'b1;
      step();
      chk("bp_full_clear", 32'(full), 0);
      chk("bp_ready_back", 32'(wr_ready), 1);
      put(8'h77, 1'b1, 1'b1);
      drain();

      // drop-on-full discards the overflowing frame
      sel = 1'b1;
      do_reset();
      for (int k = 0; k < 10; k++) put(8'(48 + k), k == 9, 1'b1);
      p0 = pulses;
      for (int k = 0; k < 6; k++) put(8'(64 + k), 1'b0, 1'b0);
      chk("dof_full", 32'(full), 1);
      chk("dof_wr_ready", 32'(wr_ready), 1);
      put(8'(70), 1'b0, 1'b0);
      put(8'(71), 1'b1, 1'b0);
      step();
      step();
      chk("dof_pulses", 32'(pulses - p0), 1);
      chk("dof_level", 32'(level), 10);
      chk("dof_fc", 32'(frame_cnt), 1);
      drain();
      sel = 1'b0;

      // almost-full / almost-empty thresholds
      do_reset();
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 4; k++)
            put(8'(80 + f * 4 + k), k == 3, 1'b1);
      chk("af_level", 32'(level), 12);
      chk("af_afull", 32'(afull), 1);
      chk("af_aempty", 32'(aempty), 0);
      rd_ready = 1'b1;
      n = 0;
      while (level != 5'd2 && n < 50) begin
         step();
         n++;
      end
      rd_ready = 1'b0;
      if (n >= 50) fail_now("ae_wait");
      step();
      chk("ae_level", 32'(level), 2);
      chk("ae_aempty", 32'(aempty), 1);
      chk("ae_afull", 32'(afull), 0);
      drain();

      // reset mid-frame with committed data waiting
      for (int k = 0; k < 4; k++) put(8'(96 + k), k == 3, 1'b1);
      put(8'(110), 1'b0, 1'b1);
      put(8'(111), 1'b0, 1'b1);
      step();
      do_reset();
      chk_reset("mid");
      for (int k = 0; k < 3; k++) put(8'(112 + k), k == 2, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_frame_fifo.md
# sync_frame_fifo

Parametrised synchronous frame FIFO for the Ethernet datapath, sitting between MAC RX/TX framing logic and packet consumers. Stores beats tagged with an end-of-frame bit, exposes a frame only after its last beat is committed, and supports aborting an in-progress frame by rolling the write pointer back. Read side is first-word-fall-through valid/ready. Occupancy, committed-frame count and runtime-programmable almost-full/almost-empty flags are provided.

## Interface
- DATA_WIDTH, 8, payload bits per beat
- DEPTH_LOG2, 11, log2 of entry count; DEPTH = 2**DEPTH_LOG2
- DROP_ON_FULL, 0, 0: backpressure via wr_ready; 1: wr_ready tied high, frames that overflow are discarded

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  write beat present
- wr_data  in  DATA_WIDTH  write payload
- wr_last  in  1  beat is last of frame (commit)
- wr_drop  in  1  abort current uncommitted frame
- wr_ready  out  1  beat accepted when wr_valid & wr_ready
- rd_valid  out  1  committed beat available on rd_data
- rd_data  out  DATA_WIDTH  read payload
- rd_last  out  1  end-of-frame tag of rd_data
- rd_ready  in  1  consumer accepts beat
- afull_th  in  DEPTH_LOG2+1  almost-full threshold
- aempty_th  in  DEPTH_LOG2+1  almost-empty threshold
- level  out  DEPTH_LOG2+1  entries written (incl. uncommitted) not yet read by handshake
- frame_cnt  out  DEPTH_LOG2+1  committed frames not fully read
- full, afull, aempty  out  1  status flags (registered)
- drop_pulse  out  1  one-cycle pulse per discarded frame

## Operation
- Pointers DEPTH_LOG2+1 bits with wrap bit: wr_ptr, commit_ptr, rd_ptr (memory fetch), acc_ptr (handshake). Memory width DATA_WIDTH+1 (last tag).
- Write: accepted beat stored at wr_ptr, wr_ptr+1. Accepted beat with wr_last: commit_ptr <= wr_ptr+1, frame_cnt+1.
- wr_drop: wr_ptr <= commit_ptr; beat presented same cycle is not written, even with wr_last (drop wins). wr_drop with no uncommitted data: no-op, no drop_pulse.
- full = (level == DEPTH). DROP_ON_FULL=0: wr_ready = ~full. DROP_ON_FULL=1: beat arriving when full sets poison; poisoned frame's beats are discarded; at its wr_last (or wr_drop) wr_ptr <= commit_ptr, poison clears, drop_pulse=1.
- Read: only data below commit_ptr is visible. rd_valid high while a committed beat sits in output stage; beat retired on rd_valid & rd_ready, acc_ptr+1; if rd_last, frame_cnt-1. Commit and final-beat read in same cycle: frame_cnt unchanged.
- level = wr_ptr - acc_ptr (wrap-bit arithmetic, DEPTH_LOG2+1 bits, max DEPTH). afull = level >= afull_th; aempty = level <= aempty_th.
- rd_valid, rd_data, rd_last hold stable while rd_valid & ~rd_ready.

## Timing
- Reset values: wr_ready = ~DROP_ON_FULL ? 1 : 1 (1), rd_valid 0, rd_data 0, rd_last 0, level 0, frame_cnt 0, full 0, afull 0, aempty 1, drop_pulse 0. All pointers 0; uncommitted and poisoned state discarded; reset mid-frame loses the frame with no drop_pulse.
- Memory read registered (BRAM inference). Commit at edge N -> rd_valid high in cycle N+2 when FIFO otherwise empty.
- Sustained 1 beat/cycle read with rd_ready held high; output uses 2-entry skid so rd_ready has no combinational path to memory address.
- full, afull, aempty, level, frame_cnt updated on the edge of the causing write/read/drop, visible next cycle.
- No combinational path from wr_* to rd_* or from rd_ready to wr_ready.

## Structure
- Package fifo_pkg: pointer-difference function (wrap-bit subtraction), width helpers for DEPTH_LOG2+1 counts.
- Sub-module sdp_ram: simple dual-port RAM, one write port, one registered read port, width DATA_WIDTH+1, depth DEPTH.
- Top holds pointer/commit/poison logic and 2-entry output skid.

## Test plan (DATA_WIDTH=8, DEPTH_LOG2=4)
- Write frame 0x10..0x13 (last on 0x13), rd_ready=1 -> rd_valid first in cycle commit+2, 4 beats back-to-back, rd_last on 0x13, frame_cnt 1 -> 0.
- Write 3 beats then wr_drop, then frame 0xA0,0xA1 -> only 0xA0,0xA1 read; level 3 -> 0 after drop.
- DROP_ON_FULL=0, rd_ready=0, write 17 beats -> wr_ready low after 16th, full=1, level=16; release rd_ready -> full clears, 17th accepted.
- DROP_ON_FULL=1, committed 10-beat frame unread, write 8-beat frame -> drop_pulse once at its wr_last, level returns to 10, only first frame read.
- afull_th=12, aempty_th=2: write 12 beats -> afull=1 after 12th; read to level 2 -> aempty=1.
- Assert rst mid-frame with committed data present -> all outputs at reset values next cycle; subsequent frame reads correctly.
